// File: rtl/input_event_manager.sv
// Board input front end: synchronises SW/KEY, debounces KEY, queues key-press events in a FIFO
// and exposes status, event pop and live switch/key levels through a registered MMIO read port.
module input_event_manager #(
    parameter int WORD_SIZE       = 8,
    parameter int FIFO_DEPTH      = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           SW,
    input  logic [3:0]           KEY,
    input  logic                 rd_en,
    input  logic [1:0]           rd_addr,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 evt_pend
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   FILL_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   FILL_FULL = (PTR_W+1)'(FIFO_DEPTH);

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_POP    = 2'd1;
    localparam logic [1:0] ADDR_SW_LO  = 2'd2;
    localparam logic [1:0] ADDR_SW_HI  = 2'd3;

    logic [9:0]           r_sw_s1;
    logic [9:0]           r_sw_s2;
    logic [3:0]           r_key_s1;
    logic [3:0]           r_key_s2;
    logic [3:0]           r_key_db;
    logic [CNT_W-1:0]     r_db_cnt [4];
    logic [3:0]           r_pending;
    logic [5:0]           r_snap   [4];
    logic [7:0]           r_mem    [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;
    logic                 r_ovf;
    logic                 r_evt_pend;
    logic [WORD_SIZE-1:0] r_rd_data;
    logic                 r_rd_valid;

    logic [3:0]           w_db_done;
    logic [3:0]           w_press;
    logic                 w_push;
    logic [1:0]           w_push_idx;
    logic [7:0]           w_push_data;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr;
    logic                 w_ovf_evt;
    logic                 w_status_rd;
    logic [PTR_W:0]       w_count_nxt;
    logic [4:0]           w_count5;
    logic [WORD_SIZE-1:0] w_rd_mux;

    // Two-flop synchronisers; keys idle high (released)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_key_s1 <= '1;
            r_key_s2 <= '1;
        end else begin
            r_sw_s1  <= SW;
            r_sw_s2  <= r_sw_s1;
            r_key_s1 <= KEY;
            r_key_s2 <= r_key_s1;
        end
    end

    always_comb begin
        w_db_done = '0;
        w_press   = '0;
        for (int i = 0; i < 4; i++) begin
            w_db_done[i] = (r_key_s2[i] != r_key_db[i]) && (r_db_cnt[i] == CNT_MAX);
            w_press[i]   = w_db_done[i] && r_key_db[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key_db <= '1;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_key_s2[i] == r_key_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (w_db_done[i]) begin
                    r_key_db[i] <= r_key_s2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Lowest pending key wins the single push slot each cycle
    always_comb begin
        w_push     = |r_pending;
        w_push_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_pending[i]) w_push_idx = 2'(i);
        end
        w_push_data = {w_push_idx, r_snap[w_push_idx]};
    end

    // A fresh press outranks the arbiter's clear so it is never lost
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            for (int i = 0; i < 4; i++) r_snap[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_press[i]) begin
                    r_pending[i] <= 1'b1;
                    r_snap[i]    <= r_sw_s2[5:0];
                end else if (w_push && (w_push_idx == 2'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FILL_FULL);
    assign w_status_rd = rd_en && (rd_addr == ADDR_STATUS);
    assign w_pop       = rd_en && (rd_addr == ADDR_POP) && !w_empty;
    assign w_wr        = w_push && (!w_full || w_pop);
    assign w_ovf_evt   = w_push && w_full && !w_pop;
    assign w_count5    = 5'(r_count);

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_pop) begin
            w_count_nxt = r_count + FILL_ONE;
        end else if (!w_wr && w_pop) begin
            w_count_nxt = r_count - FILL_ONE;
        end
    end

    // When full the write slot aliases the head; the pop still sees the old head value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_evt_pend <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count    <= w_count_nxt;
            r_evt_pend <= (w_count_nxt != '0);
            if (w_status_rd) begin
                r_ovf <= w_ovf_evt;
            end else if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (rd_addr)
            ADDR_STATUS: w_rd_mux = {r_ovf, w_full, w_empty, w_count5};
            ADDR_POP:    w_rd_mux = w_empty ? 8'h00 : r_mem[r_rd_ptr];
            ADDR_SW_LO:  w_rd_mux = r_sw_s2[7:0];
            ADDR_SW_HI:  w_rd_mux = {2'b00, ~r_key_db, r_sw_s2[9:8]};
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign evt_pend = r_evt_pend;

endmodule

// File: tb/tb_input_event_manager.sv
// Bench for input_event_manager: directed scenarios plus random key/switch activity
// checked against a transaction-level model of the event queue.
module tb_input_event_manager;

    localparam int DB    = 4;
    localparam int DEPTH = 4;

    localparam logic [1:0] A_STATUS = 2'd0;
    localparam logic [1:0] A_POP    = 2'd1;
    localparam logic [1:0] A_SW_LO  = 2'd2;
    localparam logic [1:0] A_SW_HI  = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] SW;
    logic [3:0] KEY;
    logic       rd_en;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       evt_pend;

    input_event_manager #(
        .WORD_SIZE      (8),
        .FIFO_DEPTH     (DEPTH),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .SW      (SW),
        .KEY     (KEY),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .evt_pend(evt_pend)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    logic       m_ovf     = 1'b0;
    logic [9:0] m_sw      = '0;
    logic [3:0] m_pressed = '0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk_pend(input string tag);
        chk(tag, {7'b0, evt_pend}, {7'b0, (exp_q.size() != 0)});
    endtask

    task automatic model_push(input logic [7:0] ev);
        if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
        else exp_q.push_back(ev);
    endtask

    task automatic rd_expect(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        rd_en   = 1'b1;
        rd_addr = addr;
        @(negedge clk);
        rd_en = 1'b0;
        chk({tag, "_vld"}, {7'b0, rd_valid}, 8'h01);
        chk(tag, rd_data, exp);
        @(negedge clk);
        chk({tag, "_vld0"}, {7'b0, rd_valid}, 8'h00);
        chk({tag, "_hold"}, rd_data, exp);
    endtask

    task automatic rd_pop();
        logic [7:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        rd_expect("pop", A_POP, e);
        chk_pend("pop_pend");
    endtask

    task automatic rd_status();
        logic [7:0] e;
        e = {m_ovf, (exp_q.size() == DEPTH), (exp_q.size() == 0), 5'(exp_q.size())};
        m_ovf = 1'b0;
        rd_expect("status", A_STATUS, e);
    endtask

    task automatic rd_sw_hi();
        rd_expect("sw_hi", A_SW_HI, {2'b00, m_pressed, m_sw[9:8]});
    endtask

    task automatic press(input logic [3:0] mask, input logic [9:0] sw);
        SW   = sw;
        m_sw = sw;
        tick(3);
        KEY = ~mask;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) model_push({2'(i), sw[5:0]});
        end
        tick(DB + 8);
        m_pressed = mask;
        rd_sw_hi();
        KEY       = 4'hF;
        m_pressed = 4'h0;
        tick(DB + 6);
    endtask

    initial begin
        reset   = 1'b0;
        SW      = '0;
        KEY     = 4'hF;
        rd_en   = 1'b0;
        rd_addr = 2'd0;
        tick(3);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_rd_valid", {7'b0, rd_valid}, 8'h00);
        chk("rst_evt_pend", {7'b0, evt_pend}, 8'h00);
        reset = 1'b1;
        tick(2);
        rd_expect("rst_status", A_STATUS, 8'h20);
        rd_sw_hi();

        // Scenario 1: short glitch ignored, then a held press gives exactly one event
        SW = 10'h02A; m_sw = 10'h02A;
        tick(3);
        KEY[0] = 1'b0;
        tick(3);
        KEY[0] = 1'b1;
        tick(DB + 6);
        chk("t1_glitch_pend", {7'b0, evt_pend}, 8'h00);
        KEY[0] = 1'b0;
        tick(6);
        chk("t1_pend_before", {7'b0, evt_pend}, 8'h00);
        tick(1);
        chk("t1_pend_after", {7'b0, evt_pend}, 8'h01);
        model_push({2'd0, m_sw[5:0]});
        tick(3);
        KEY[0] = 1'b1;
        tick(DB + 6);
        rd_expect("t1_status", A_STATUS, 8'h01);
        rd_pop();

        // Scenario 2
        press(4'b0100, 10'h015);
        rd_expect("t2_pop", A_POP, 8'h95);
        void'(exp_q.pop_front());
        rd_expect("t2_pop_empty", A_POP, 8'h00);
        rd_expect("t2_status", A_STATUS, 8'h20);
        chk_pend("t2_pend");

        // Scenario 3
        press(4'b1010, 10'h003);
        rd_expect("t3_pop_a", A_POP, 8'h43);
        rd_expect("t3_pop_b", A_POP, 8'hC3);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        chk_pend("t3_pend");

        // Scenario 4
        for (int n = 0; n < 5; n++) press(4'b0001 << (n % 4), 10'($urandom));
        chk_pend("t4_pend");
        rd_expect("t4_status_a", A_STATUS, 8'hC4);
        rd_expect("t4_status_b", A_STATUS, 8'h44);
        m_ovf = 1'b0;

        // Scenario 5: pop lands in the same cycle as a push into a full FIFO
        SW = 10'h011; m_sw = 10'h011;
        tick(3);
        KEY[1] = 1'b0;
        tick(6);
        rd_en   = 1'b1;
        rd_addr = A_POP;
        @(negedge clk);
        rd_en = 1'b0;
        chk("t5_vld", {7'b0, rd_valid}, 8'h01);
        chk("t5_pop", rd_data, exp_q.pop_front());
        exp_q.push_back({2'd1, 6'h11});
        tick(DB);
        KEY[1] = 1'b1;
        tick(DB + 6);
        rd_expect("t5_status", A_STATUS, 8'h44);
        for (int n = 0; n < DEPTH; n++) rd_pop();
        rd_status();

        // Scenario 6: reset mid-debounce with events queued and a read in flight
        press(4'b0001, 10'h001);
        press(4'b0010, 10'h002);
        KEY[2] = 1'b0;
        tick(3);
        rd_en   = 1'b1;
        rd_addr = A_STATUS;
        #2 reset = 1'b0;
        tick(2);
        chk("t6_rst_vld", {7'b0, rd_valid}, 8'h00);
        chk("t6_rst_pend", {7'b0, evt_pend}, 8'h00);
        chk("t6_rst_data", rd_data, 8'h00);
        rd_en = 1'b0;
        KEY   = 4'hF;
        exp_q.delete();
        m_ovf = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("t6_vld_after", {7'b0, rd_valid}, 8'h00);
        chk("t6_data_after", rd_data, 8'h00);
        tick(DB + 6);
        chk_pend("t6_pend_after");
        rd_expect("t6_status", A_STATUS, 8'h20);

        // Random activity against the model
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0: press(4'($urandom_range(1, 15)), 10'($urandom));
                1: begin
                    int k;
                    k = $urandom_range(0, 3);
                    KEY[k] = 1'b0;
                    tick($urandom_range(1, DB - 1));
                    KEY = 4'hF;
                    tick(DB + 6);
                    chk_pend("rnd_glitch_pend");
                end
                2: rd_pop();
                3: rd_status();
                4: begin
                    m_sw = 10'($urandom);
                    SW   = m_sw;
                    tick(3);
                    rd_expect("sw_lo", A_SW_LO, m_sw[7:0]);
                end
                default: rd_sw_hi();
            endcase
        end
        while (exp_q.size() != 0) rd_pop();
        rd_status();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
